proc_out_capture: RTL

- Downstream consumer of the processor core's 16-bit `data_out` result bus.
- The core gives no valid strobe, so this block detects value changes itself.
- Each new result is timestamped with a free-running cycle counter and buffered in a FIFO.
- Results drain over a valid/ready stream to the trace/UART/debug logic, with overflow accounting.

---
 rtl/proc_out_capture_pkg.sv | 17 +
 rtl/proc_out_capture_if.sv | 13 +
 rtl/proc_out_capture_sync_fifo_fwft.sv | 59 +++++
 rtl/proc_out_capture.sv | 88 ++++++++
 4 files changed

// File: rtl/proc_out_capture_pkg.sv
// proc_cap_pkg: shared widths, captured-entry layout and occupancy helper
package proc_cap_pkg;

    localparam int CAP_DATA_W = 16;
    localparam int CAP_TS_W   = 16;

    typedef struct packed {
        logic [CAP_DATA_W-1:0] data;
        logic [CAP_TS_W-1:0]   ts;
    } cap_entry_t;

    // Occupancy counter must represent 0..depth inclusive
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/proc_out_capture_if.sv
// proc_out_capture_if: valid/ready stream carrying timestamped results
interface proc_out_capture_if #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 16
);
    logic [DATA_W-1:0] m_data;
    logic [TS_W-1:0]   m_ts;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, m_ts, m_valid, input m_ready);
    modport slave  (input m_data, m_ts, m_valid, output m_ready);
endinterface

// File: rtl/proc_out_capture_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with drop reporting when full
module sync_fifo_fwft #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands when paired with a pop
    always_comb begin
        full    = level == LW'(DEPTH);
        valid   = level != '0;
        do_pop  = pop && valid && !clr;
        do_push = push && !clr && (!full || do_pop);
        drop    = push && !clr && full && !do_pop;
        rdata   = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; flush discards contents by resetting pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset; only entries behind the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/proc_out_capture.sv
// proc_out_capture: detects changes on the core result bus, timestamps and buffers them
module proc_out_capture
    import proc_cap_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W,
    parameter int TS_W   = CAP_TS_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           proc_in,
    input  logic                        cap_en,
    input  logic                        clr,
    proc_out_capture_if.master          m,
    output logic [occ_w(DEPTH)-1:0]     level,
    output logic                        overflow,
    output logic [CNT_W-1:0]            drop_cnt
);
    localparam int EW = DATA_W + TS_W;

    logic [TS_W-1:0]   ts;
    logic              primed;
    logic [DATA_W-1:0] last_val;
    logic              cap_req;
    logic              drop;
    logic [EW-1:0]     head;

    // The core has no strobe: any new value, or the first sample once unprimed, is a result
    always_comb begin
        cap_req = cap_en && !clr && (!primed || proc_in != last_val);
    end

    assign m.m_data = head[EW-1:TS_W];
    assign m.m_ts   = head[TS_W-1:0];

    sync_fifo_fwft #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (cap_req),
        .wdata ({proc_in, ts}),
        .pop   (m.m_ready),
        .rdata (head),
        .valid (m.m_valid),
        .level (level),
        .drop  (drop)
    );

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else if (clr) ts <= '0;
        else ts <= ts + 1'b1;
    end

    // Change reference updates even on a drop so a held value is not re-captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed   <= 1'b0;
            last_val <= '0;
        end else if (clr) begin
            primed   <= 1'b0;
            last_val <= '0;
        end else if (cap_req) begin
            primed   <= 1'b1;
            last_val <= proc_in;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= (drop_cnt == '1) ? drop_cnt : drop_cnt + 1'b1;
        end
    end

endmodule
